// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, ALU operation and immediate-format types for the
// single-cycle core.
package rv32i_pkg;

  localparam int REG_W = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  // alt selects SUB/SRA; callers decide when funct7[5] is meaningful
  function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 31 writable 32-bit registers with x0 hardwired to zero; two operand read
// ports and one debug read port, all combinational.
module rv32i_regfile
  import rv32i_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [REG_W-1:0] wdata_i,
  input  logic [4:0]       raddr1_i,
  output logic [REG_W-1:0] rdata1_o,
  input  logic [4:0]       raddr2_i,
  output logic [REG_W-1:0] rdata2_o,
  input  logic [4:0]       dbg_addr_i,
  output logic [REG_W-1:0] dbg_data_o
);

  logic [REG_W-1:0] regs_q [1:NREGS-1];

  function automatic logic [REG_W-1:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0) begin
      return {REG_W{1'b0}};
    end else begin
      return regs_q[addr];
    end
  endfunction

  // Register storage: cleared asynchronously, one write per clock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= {REG_W{1'b0}};
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = read_port(raddr1_i);
  assign rdata2_o   = read_port(raddr2_i);
  assign dbg_data_o = read_port(dbg_addr_i);

endmodule

// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I integer core (no data memory): fetch, decode, execute
// and write back in one clock; unsupported encodings retire as NOPs.
module rv32i_cpu
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_pc,
  input  logic [31:0]     im_data,
  output logic [XLEN-1:0] im_addr,
  input  logic [4:0]      dbg_reg_sel,
  output logic [XLEN-1:0] dbg_reg_data
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [6:0]      opcode_s, funct7_s;
  logic [2:0]      funct3_s;
  logic [4:0]      rd_s, rs1_s, rs2_s;
  logic [XLEN-1:0] rs1_data_s, rs2_data_s, imm_s, alu_a_s, alu_b_s, alu_res_s;
  logic [XLEN-1:0] pc_plus4_s, target_s, wb_data_s;
  logic [4:0]      shamt_s;
  alu_op_t         alu_op_s;
  imm_fmt_t        imm_fmt_s;
  logic            rd_we_s, a_pc_s, b_imm_s, link_s, branch_s, jal_s, jalr_s, taken_s;

  assign opcode_s = im_data[6:0];
  assign rd_s     = im_data[11:7];
  assign funct3_s = im_data[14:12];
  assign rs1_s    = im_data[19:15];
  assign rs2_s    = im_data[24:20];
  assign funct7_s = im_data[31:25];

  rv32i_regfile u_regfile (
    .clk_i      (clk),
    .rst_i      (reset_pc),
    .we_i       (rd_we_s),
    .waddr_i    (rd_s),
    .wdata_i    (wb_data_s),
    .raddr1_i   (rs1_s),
    .rdata1_o   (rs1_data_s),
    .raddr2_i   (rs2_s),
    .rdata2_o   (rs2_data_s),
    .dbg_addr_i (dbg_reg_sel),
    .dbg_data_o (dbg_reg_data)
  );

  // Decoder: anything not explicitly recognised keeps the NOP defaults
  always_comb begin
    rd_we_s   = 1'b0;
    alu_op_s  = ALU_ADD;
    imm_fmt_s = IMM_I;
    a_pc_s    = 1'b0;
    b_imm_s   = 1'b1;
    link_s    = 1'b0;
    branch_s  = 1'b0;
    jal_s     = 1'b0;
    jalr_s    = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        rd_we_s   = 1'b1;
        alu_op_s  = ALU_PASS_B;
        imm_fmt_s = IMM_U;
      end
      OPC_AUIPC: begin
        rd_we_s   = 1'b1;
        a_pc_s    = 1'b1;
        imm_fmt_s = IMM_U;
      end
      OPC_JAL: begin
        rd_we_s   = 1'b1;
        link_s    = 1'b1;
        jal_s     = 1'b1;
        imm_fmt_s = IMM_J;
      end
      OPC_JALR: begin
        if (funct3_s == F3_JALR) begin
          rd_we_s = 1'b1;
          link_s  = 1'b1;
          jalr_s  = 1'b1;
        end else begin
          rd_we_s = 1'b0;
        end
      end
      OPC_BRANCH: begin
        branch_s  = 1'b1;
        imm_fmt_s = IMM_B;
      end
      OPC_OP_IMM: begin
        alu_op_s = f3_to_alu(funct3_s, (funct3_s == F3_SR) && funct7_s[5]);
        case (funct3_s)
          F3_SLL:  rd_we_s = (funct7_s == F7_BASE);
          F3_SR:   rd_we_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
          default: rd_we_s = 1'b1;
        endcase
      end
      OPC_OP: begin
        b_imm_s  = 1'b0;
        alu_op_s = f3_to_alu(funct3_s, funct7_s[5]);
        if (funct7_s == F7_BASE) begin
          rd_we_s = 1'b1;
        end else if (funct7_s == F7_ALT) begin
          rd_we_s = (funct3_s == F3_ADD_SUB) || (funct3_s == F3_SR);
        end else begin
          rd_we_s = 1'b0;
        end
      end
      default: rd_we_s = 1'b0;
    endcase
  end

  // Immediate generation and ALU operand selection
  always_comb begin
    imm_s = {XLEN{1'b0}};
    case (imm_fmt_s)
      IMM_I:   imm_s = {{20{im_data[31]}}, im_data[31:20]};
      IMM_S:   imm_s = {{20{im_data[31]}}, im_data[31:25], im_data[11:7]};
      IMM_B:   imm_s = {{19{im_data[31]}}, im_data[31], im_data[7], im_data[30:25], im_data[11:8], 1'b0};
      IMM_U:   imm_s = {im_data[31:12], 12'h000};
      IMM_J:   imm_s = {{11{im_data[31]}}, im_data[31], im_data[19:12], im_data[20], im_data[30:21], 1'b0};
      default: imm_s = {XLEN{1'b0}};
    endcase
    alu_a_s = a_pc_s  ? pc_q  : rs1_data_s;
    alu_b_s = b_imm_s ? imm_s : rs2_data_s;
  end

  assign shamt_s = alu_b_s[4:0];

  // ALU
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    case (alu_op_s)
      ALU_ADD:    alu_res_s = alu_a_s + alu_b_s;
      ALU_SUB:    alu_res_s = alu_a_s - alu_b_s;
      ALU_SLL:    alu_res_s = alu_a_s << shamt_s;
      ALU_SLT:    alu_res_s = {{(XLEN-1){1'b0}}, $signed(alu_a_s) < $signed(alu_b_s)};
      ALU_SLTU:   alu_res_s = {{(XLEN-1){1'b0}}, alu_a_s < alu_b_s};
      ALU_XOR:    alu_res_s = alu_a_s ^ alu_b_s;
      ALU_SRL:    alu_res_s = alu_a_s >> shamt_s;
      ALU_SRA:    alu_res_s = $signed(alu_a_s) >>> shamt_s;
      ALU_OR:     alu_res_s = alu_a_s | alu_b_s;
      ALU_AND:    alu_res_s = alu_a_s & alu_b_s;
      ALU_PASS_B: alu_res_s = alu_b_s;
      default:    alu_res_s = {XLEN{1'b0}};
    endcase
  end

  // Branch condition; reserved funct3 values never take the branch
  always_comb begin
    taken_s = 1'b0;
    case (funct3_s)
      F3_BEQ:  taken_s = (rs1_data_s == rs2_data_s);
      F3_BNE:  taken_s = (rs1_data_s != rs2_data_s);
      F3_BLT:  taken_s = ($signed(rs1_data_s) <  $signed(rs2_data_s));
      F3_BGE:  taken_s = ($signed(rs1_data_s) >= $signed(rs2_data_s));
      F3_BLTU: taken_s = (rs1_data_s <  rs2_data_s);
      F3_BGEU: taken_s = (rs1_data_s >= rs2_data_s);
      default: taken_s = 1'b0;
    endcase
  end

  // Next PC and write-back selection
  always_comb begin
    pc_plus4_s = pc_q + XLEN'(4);
    target_s   = pc_q + imm_s;
    wb_data_s  = link_s ? pc_plus4_s : alu_res_s;
    if (jal_s || (branch_s && taken_s)) begin
      pc_d = target_s;
    end else if (jalr_s) begin
      pc_d = alu_res_s & ~XLEN'(1);
    end else begin
      pc_d = pc_plus4_s;
    end
  end

  // Program counter
  always_ff @(posedge clk or posedge reset_pc) begin
    if (reset_pc) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign im_addr = pc_q;

endmodule

// File: tb/tb_rv32i_cpu.sv
// Scoreboard bench for rv32i_cpu: directed programs with fixed expectations,
// then random instruction streams checked against an ISA-level model.
module tb_rv32i_cpu;

  logic        clk;
  logic        reset_pc;
  logic [31:0] im_data;
  logic [31:0] im_addr;
  logic [4:0]  dbg_reg_sel;
  logic [31:0] dbg_reg_data;

  rv32i_cpu dut (
    .clk          (clk),
    .reset_pc     (reset_pc),
    .im_data      (im_data),
    .im_addr      (im_addr),
    .dbg_reg_sel  (dbg_reg_sel),
    .dbg_reg_data (dbg_reg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [4:0]  ridx;
    logic [31:0] rval;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] opc);
    return {imm, rd, opc};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  // ---------------- ISA reference model ----------------
  logic [31:0] m_x [32];
  logic [31:0] m_pc;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
    m_pc = 32'h0;
  endfunction

  // Executes one instruction; returns the register written or -1
  function automatic int m_exec(input logic [31:0] ins);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a, b, ii, iu, ib, ij, v, npc;
    logic        wr, tk;
    opc = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
    a  = m_x[ins[19:15]];
    b  = m_x[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    iu = {ins[31:12], 12'h000};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = m_pc + 32'd4; wr = 1'b0; v = 32'h0; tk = 1'b0;
    case (opc)
      7'h37: begin wr = 1'b1; v = iu; end
      7'h17: begin wr = 1'b1; v = m_pc + iu; end
      7'h6F: begin wr = 1'b1; v = m_pc + 32'd4; npc = m_pc + ij; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; v = m_pc + 32'd4; npc = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) <  $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a <  b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) npc = m_pc + ib;
      end
      7'h13: begin
        wr = 1'b1;
        case (f3)
          3'd0: v = a + ii;
          3'd2: v = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd3: v = (a < ii) ? 32'd1 : 32'd0;
          3'd4: v = a ^ ii;
          3'd6: v = a | ii;
          3'd7: v = a & ii;
          3'd1: if (f7 == 7'h00) v = a << ii[4:0]; else wr = 1'b0;
          default: begin
            if (f7 == 7'h00)      v = a >> ii[4:0];
            else if (f7 == 7'h20) v = $signed(a) >>> ii[4:0];
            else                  wr = 1'b0;
          end
        endcase
      end
      7'h33: begin
        wr = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: v = a + b;
          {7'h20, 3'd0}: v = a - b;
          {7'h00, 3'd1}: v = a << b[4:0];
          {7'h00, 3'd2}: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          {7'h00, 3'd3}: v = (a < b) ? 32'd1 : 32'd0;
          {7'h00, 3'd4}: v = a ^ b;
          {7'h00, 3'd5}: v = a >> b[4:0];
          {7'h20, 3'd5}: v = $signed(a) >>> b[4:0];
          {7'h00, 3'd6}: v = a | b;
          {7'h00, 3'd7}: v = a & b;
          default: wr = 1'b0;
        endcase
      end
      default: wr = 1'b0;
    endcase
    if (wr && rd != 5'd0) m_x[rd] = v;
    m_pc = npc;
    return (wr && rd != 5'd0) ? int'(rd) : -1;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [6:0]  f7, opc;
    logic [4:0]  rd, rs1, rs2;
    r   = $urandom();
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    case ($urandom_range(0, 15))
      0:          opc = 7'h37;
      1:          opc = 7'h17;
      2:          opc = 7'h6F;
      3:          opc = 7'h67;
      4, 5:       opc = 7'h63;
      6, 7, 8:    opc = 7'h13;
      9, 10, 11:  opc = 7'h33;
      12:         opc = 7'h03;
      13:         opc = 7'h23;
      14:         opc = 7'h73;
      default:    return r;
    endcase
    if (opc == 7'h67 && r[0]) r[14:12] = 3'b000;
    return {f7, rs2, rs1, r[14:12], rd, opc};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] pc_exp,
                       input logic [4:0] ridx, input logic [31:0] rval);
    exp_t e;
    @(negedge clk);
    reset_pc = 1'b0;
    im_data  = ins;
    e.tag = tag; e.pc = pc_exp; e.ridx = ridx; e.rval = rval;
    sb_q.push_back(e);
  endtask

  task automatic hold_reset(input int edges);
    exp_t e;
    for (int k = 0; k < edges; k++) begin
      @(negedge clk);
      reset_pc = 1'b1;
      im_data  = enc_i(12'h055, 5'd0, 3'd0, 5'(k + 1), 7'h13);
      e.tag = "reset"; e.pc = 32'h0; e.ridx = 5'(k + 1); e.rval = 32'h0;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per executed edge
  initial begin
    exp_t e;
    dbg_reg_sel = 5'd0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, "_pc"}, im_addr, e.pc);
        dbg_reg_sel = e.ridx;
        #1;
        check({e.tag, "_reg"}, dbg_reg_data, e.rval);
      end
    end
  end

  initial begin
    logic [31:0] ins;
    int          rd;
    logic [4:0]  idx;
    reset_pc = 1'b1;
    im_data  = NOP;

    // ALU group
    hold_reset(10);
    issue("addi5",  enc_i(12'd5,   5'd0, 3'd0, 5'd1, 7'h13), 32'h04, 5'd1, 32'd5);
    issue("addim3", enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13), 32'h08, 5'd2, 32'hFFFF_FFFD);
    issue("add",    enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3),    32'h0C, 5'd3, 32'd2);
    issue("sub",    enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4),    32'h10, 5'd4, 32'd8);
    issue("slt",    enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5),    32'h14, 5'd5, 32'd1);
    issue("sltu",   enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd6),    32'h18, 5'd6, 32'd0);
    issue("srai",   enc_i(12'h401, 5'd2, 3'd5, 5'd7, 7'h13), 32'h1C, 5'd7, 32'hFFFF_FFFE);

    // Upper immediates, then branches
    hold_reset(10);
    issue("lui",    enc_u(20'h12345, 5'd8, 7'h37),           32'h04, 5'd8, 32'h1234_5000);
    issue("addilo", enc_i(12'h678, 5'd8, 3'd0, 5'd8, 7'h13), 32'h08, 5'd8, 32'h1234_5678);
    issue("nop",    NOP,                                     32'h0C, 5'd8, 32'h1234_5678);
    issue("auipc",  enc_u(20'h00001, 5'd9, 7'h17),           32'h10, 5'd9, 32'h0000_100C);
    issue("beq",    enc_b(13'd8, 5'd1, 5'd1, 3'd0),          32'h18, 5'd9, 32'h0000_100C);
    issue("bne",    enc_b(13'd8, 5'd1, 5'd1, 3'd1),          32'h1C, 5'd0, 32'h0);
    issue("addi5b", enc_i(12'd5,   5'd0, 3'd0, 5'd1, 7'h13), 32'h20, 5'd1, 32'd5);
    issue("addim3b",enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13), 32'h24, 5'd2, 32'hFFFF_FFFD);
    issue("bltu",   enc_b(13'd8, 5'd1, 5'd2, 3'd6),          32'h28, 5'd1, 32'd5);
    issue("blt",    enc_b(13'd8, 5'd1, 5'd2, 3'd4),          32'h30, 5'd2, 32'hFFFF_FFFD);

    // x0, NOP-class opcode, jumps and asynchronous reset
    hold_reset(10);
    issue("x0wr",   enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13),   32'h04, 5'd0, 32'h0);
    issue("addi9",  enc_i(12'd9, 5'd0, 3'd0, 5'd5, 7'h13),   32'h08, 5'd5, 32'd9);
    issue("load",   enc_i(12'd0, 5'd0, 3'd2, 5'd5, 7'h03),   32'h0C, 5'd5, 32'd9);
    for (int k = 0; k < 5; k++) issue("pad", NOP, 32'h10 + 32'(4 * k), 5'd5, 32'd9);
    issue("jal",    enc_j(21'd16, 5'd1),                     32'h30, 5'd1, 32'h24);
    issue("jalr",   enc_i(12'd1, 5'd1, 3'd0, 5'd0, 7'h67),   32'h24, 5'd0, 32'h0);
    @(negedge clk);
    reset_pc = 1'b1;
    #1;
    check("async_reset_pc", im_addr, 32'h0);
    hold_reset(4);

    // Random streams against the model
    for (int blk = 0; blk < 3; blk++) begin
      hold_reset(6);
      m_reset();
      for (int n = 0; n < 600; n++) begin
        ins = gen_instr();
        rd  = m_exec(ins);
        idx = (rd >= 0) ? 5'(rd) : 5'($urandom_range(0, 31));
        issue("rand", ins, m_pc, idx, m_x[idx]);
      end
    end

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drain", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
